// File: rtl/dmem_arbiter.sv
// ----------------------------------------------------------------------------
// dmem_arbiter
//   Two-requester arbiter in front of the single-port data memory.
//   Port 0 is the core load/store unit and port 1 is the DMA/debug master.
//   At most one access is granted per cycle. Read data is registered and
//   returned to its owner one cycle after the grant. Port 1 can lock the
//   memory for a burst, and a starvation counter stops port 0 from shutting
//   port 1 out indefinitely.
//
//   Optional feature (macro DMEM_ADDR_CHECK_EN):
//     defined   - an access with addr >= MEM_DEPTH is still granted, but its
//                 write is suppressed, its read data is 0, and mX_err is
//                 raised together with mX_rvalid on the next cycle. This also
//                 applies to writes.
//     undefined - no address check; mX_err stays 0.
//
// Ports
//   clk, rst_n                 clock, async active-low reset
//   m0_req/we/addr/wdata       port 0 request (held until m0_gnt)
//   m0_gnt                     port 0 accepted this cycle (combinational)
//   m0_rvalid/rdata/err        port 0 read return, one cycle after grant
//   m1_*                       same set for port 1, plus m1_lock
//   m1_lock                    keep the memory after this port-1 access
//   mem_a/mem_wd/mem_we        memory port, driven by the granted master
//   mem_rd                     combinational memory read data
// ----------------------------------------------------------------------------
// state    | meaning
// ST_ARB   | normal arbitration: m0 by default, m1 if m0 idle or m1 starved
// ST_LOCK1 | m1 owns the memory; m0 is stalled until m1 unlocks or goes idle
// ----------------------------------------------------------------------------
module dmem_arbiter #(
   parameter int ADDR_W     = 32,
   parameter int DATA_W     = 32,
   parameter int MEM_DEPTH  = 1024,
   parameter int STARVE_MAX = 4
) (
   input  logic              clk,
   input  logic              rst_n,

   input  logic              m0_req,
   input  logic              m0_we,
   input  logic [ADDR_W-1:0] m0_addr,
   input  logic [DATA_W-1:0] m0_wdata,
   output logic              m0_gnt,
   output logic              m0_rvalid,
   output logic [DATA_W-1:0] m0_rdata,
   output logic              m0_err,

   input  logic              m1_req,
   input  logic              m1_we,
   input  logic              m1_lock,
   input  logic [ADDR_W-1:0] m1_addr,
   input  logic [DATA_W-1:0] m1_wdata,
   output logic              m1_gnt,
   output logic              m1_rvalid,
   output logic [DATA_W-1:0] m1_rdata,
   output logic              m1_err,

   output logic [ADDR_W-1:0] mem_a,
   output logic [DATA_W-1:0] mem_wd,
   output logic              mem_we,
   input  logic [DATA_W-1:0] mem_rd
);

   localparam logic [0:0] ST_ARB   = 1'b0;
   localparam logic [0:0] ST_LOCK1 = 1'b1;

   localparam logic [3:0]      STARVE_LIM = 4'(STARVE_MAX);
   localparam logic [ADDR_W:0] DEPTH_LIM  = (ADDR_W+1)'(MEM_DEPTH);

`ifdef DMEM_ADDR_CHECK_EN
   localparam logic CHK_EN = 1'b1;
`else
   localparam logic CHK_EN = 1'b0;
`endif

   logic [0:0] state;
   logic [0:0] state_nxt;
   logic [3:0] starve_cnt;
   logic       bad0;
   logic       bad1;

   assign bad0 = CHK_EN && ({1'b0, m0_addr} >= DEPTH_LIM);
   assign bad1 = CHK_EN && ({1'b0, m1_addr} >= DEPTH_LIM);

   // Grants are forced low while reset is asserted so nothing reaches the
   // memory during reset, even though the state register already reads ARB.
   always_comb begin
      m0_gnt    = 1'b0;
      m1_gnt    = 1'b0;
      state_nxt = state;
      if (rst_n) begin
         case (state)
            ST_ARB: begin
               if (m1_req && (!m0_req || (starve_cnt == STARVE_LIM)))
                  m1_gnt = 1'b1;
               else
                  m0_gnt = m0_req;
               if (m1_gnt && m1_lock)
                  state_nxt = ST_LOCK1;
            end
            ST_LOCK1: begin
               m1_gnt = m1_req;
               // an unlocked access or an idle cycle both release the lock
               if (!m1_req || !m1_lock)
                  state_nxt = ST_ARB;
            end
            default: state_nxt = ST_ARB;
         endcase
      end
   end

   assign mem_a  = m1_gnt ? m1_addr  : m0_addr;
   assign mem_wd = m1_gnt ? m1_wdata : m0_wdata;
   assign mem_we = (m0_gnt & m0_we & ~bad0) | (m1_gnt & m1_we & ~bad1);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= ST_ARB;
         starve_cnt <= '0;
      end else begin
         state <= state_nxt;
         if (m1_req && !m1_gnt) begin
            if (starve_cnt != STARVE_LIM)
               starve_cnt <= starve_cnt + 4'd1;
         end else begin
            starve_cnt <= '0;
         end
      end
   end

   // Read return. An out-of-range access answers like a read (rvalid with
   // err) so the master always learns that its access was rejected.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m0_rvalid <= 1'b0;
         m0_err    <= 1'b0;
         m0_rdata  <= '0;
         m1_rvalid <= 1'b0;
         m1_err    <= 1'b0;
         m1_rdata  <= '0;
      end else begin
         m0_rvalid <= m0_gnt & (~m0_we | bad0);
         m0_err    <= m0_gnt & bad0;
         if (m0_gnt && (!m0_we || bad0))
            m0_rdata <= bad0 ? '0 : mem_rd;
         m1_rvalid <= m1_gnt & (~m1_we | bad1);
         m1_err    <= m1_gnt & bad1;
         if (m1_gnt && (!m1_we || bad1))
            m1_rdata <= bad1 ? '0 : mem_rd;
      end
   end

endmodule

// File: tb/tb_dmem_arbiter.sv
// ----------------------------------------------------------------------------
// tb_dmem_arbiter
//   Directed bench for dmem_arbiter with a 1024-word behavioural memory.
//   Inputs change 1 time unit after the rising edge; combinational grants
//   and registered outputs are sampled a further unit later.
// ----------------------------------------------------------------------------
module tb_dmem_arbiter;

   logic        clk;
   logic        rst_n;
   logic        m0_req, m0_we;
   logic [31:0] m0_addr, m0_wdata;
   logic        m0_gnt, m0_rvalid, m0_err;
   logic [31:0] m0_rdata;
   logic        m1_req, m1_we, m1_lock;
   logic [31:0] m1_addr, m1_wdata;
   logic        m1_gnt, m1_rvalid, m1_err;
   logic [31:0] m1_rdata;
   logic [31:0] mem_a, mem_wd, mem_rd;
   logic        mem_we;

   logic [31:0] mem [0:1023];

   int checks = 0;
   int errors = 0;

   dmem_arbiter #(
      .ADDR_W(32), .DATA_W(32), .MEM_DEPTH(1024), .STARVE_MAX(4)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
      .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata), .m0_err(m0_err),
      .m1_req(m1_req), .m1_we(m1_we), .m1_lock(m1_lock), .m1_addr(m1_addr),
      .m1_wdata(m1_wdata), .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid),
      .m1_rdata(m1_rdata), .m1_err(m1_err),
      .mem_a(mem_a), .mem_wd(mem_wd), .mem_we(mem_we), .mem_rd(mem_rd)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   assign mem_rd = mem_we ? 32'h0 : mem[mem_a[9:0]];

   initial begin
      for (int i = 0; i < 1024; i++) mem[i] <= 32'h0;
      mem[10] <= 32'hA0A0_0010;
      mem[20] <= 32'hB1B1_0020;
      forever begin
         @(posedge clk);
         if (mem_we) mem[mem_a[9:0]] <= mem_wd;
      end
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst_n = 1'b0;
      m0_req = 0; m0_we = 0; m0_addr = 0; m0_wdata = 0;
      m1_req = 0; m1_we = 0; m1_lock = 0; m1_addr = 0; m1_wdata = 0;

      // reset: grants and write enable held low even with a request pending
      #2;
      m0_req = 1; m0_we = 1; m0_addr = 5; m0_wdata = 32'h1234;
      #1;
      chk("rst_m0_gnt",    m0_gnt,    0);
      chk("rst_mem_we",    mem_we,    0);
      chk("rst_m0_rvalid", m0_rvalid, 0);
      chk("rst_m0_rdata",  m0_rdata,  0);
      chk("rst_m1_rvalid", m1_rvalid, 0);
      chk("rst_m0_err",    m0_err,    0);
      m0_req = 0; m0_we = 0;
      @(negedge clk);
      rst_n = 1'b1;
      tick;

      // 1: m0 write addr 5, then read it back
      m0_req = 1; m0_we = 1; m0_addr = 5; m0_wdata = 32'hDEAD_BEEF;
      #1;
      chk("t1_wr_gnt",   m0_gnt, 1);
      chk("t1_wr_memwe", mem_we, 1);
      chk("t1_wr_mema",  mem_a,  5);
      tick;
      m0_we = 0;
      #1;
      chk("t1_rd_gnt",        m0_gnt,    1);
      chk("t1_wr_no_rvalid",  m0_rvalid, 0);
      tick;
      m0_req = 0;
      #1;
      chk("t1_rvalid", m0_rvalid, 1);
      chk("t1_rdata",  m0_rdata,  32'hDEAD_BEEF);
      chk("t1_err",    m0_err,    0);
      tick;
      chk("t1_rvalid_pulse", m0_rvalid, 0);

      // 2: both masters read continuously; m1 wins every fifth cycle
      m0_req = 1; m0_we = 0; m0_addr = 10;
      m1_req = 1; m1_we = 0; m1_lock = 0; m1_addr = 20;
      #1;
      for (int i = 0; i < 10; i++) begin
         chk("t2_m0_gnt",    m0_gnt,    (i % 5) != 4);
         chk("t2_m1_gnt",    m1_gnt,    (i % 5) == 4);
         chk("t2_m1_rvalid", m1_rvalid, (i % 5) == 0 && i != 0);
         chk("t2_m0_rvalid", m0_rvalid, (i % 5) != 0 || i == 0 ? (i != 0) : 1'b0);
         tick;
         #1;
      end
      m0_req = 0; m1_req = 0;
      #1;
      chk("t2_m1_rvalid_end", m1_rvalid, 1);
      chk("t2_m1_rdata",      m1_rdata,  32'hB1B1_0020);
      chk("t2_m0_rdata",      m0_rdata,  32'hA0A0_0010);
      tick;

      // 3: locked m1 write burst to addrs 0..3, m0 stalled until unlock
      m1_req = 1; m1_we = 1; m1_lock = 1; m1_addr = 0; m1_wdata = 100;
      #1;
      chk("t3_b0_m1_gnt", m1_gnt, 1);
      chk("t3_b0_m0_gnt", m0_gnt, 0);
      tick;
      m0_req = 1; m0_we = 0; m0_addr = 10;
      for (int k = 1; k < 4; k++) begin
         m1_addr = k; m1_wdata = 100 + k; m1_lock = (k < 3);
         #1;
         chk("t3_burst_m1_gnt", m1_gnt, 1);
         chk("t3_burst_m0_gnt", m0_gnt, 0);
         chk("t3_burst_memwe",  mem_we, 1);
         tick;
      end
      m1_req = 0; m1_lock = 0;
      #1;
      chk("t3_after_m0_gnt", m0_gnt, 1);
      chk("t3_after_m1_gnt", m1_gnt, 0);
      tick;
      m0_req = 0;
      m1_req = 1; m1_we = 0; m1_addr = 2;
      #1;
      chk("t3_m0_rvalid",  m0_rvalid, 1);
      chk("t3_m0_rdata",   m0_rdata,  32'hA0A0_0010);
      chk("t3_m1_rd_gnt",  m1_gnt,    1);
      tick;
      m1_req = 0;
      #1;
      chk("t3_m1_rvalid", m1_rvalid, 1);
      chk("t3_m1_rdata",  m1_rdata,  102);
      tick;

      // 4: reset pulse while locked with read data in flight
      m1_req = 1; m1_we = 0; m1_lock = 1; m1_addr = 3;
      tick;
      m0_req = 1; m0_we = 0; m0_addr = 10;
      #1;
      chk("t4_inflight_rvalid", m1_rvalid, 1);
      chk("t4_lock_m0_gnt",     m0_gnt,    0);
      chk("t4_lock_m1_gnt",     m1_gnt,    1);
      rst_n = 1'b0;
      #1;
      chk("t4_rst_m1_rvalid", m1_rvalid, 0);
      chk("t4_rst_m1_rdata",  m1_rdata,  0);
      chk("t4_rst_m0_gnt",    m0_gnt,    0);
      chk("t4_rst_m1_gnt",    m1_gnt,    0);
      chk("t4_rst_memwe",     mem_we,    0);
      m1_lock = 0;
      #1;
      rst_n = 1'b1;
      #1;
      chk("t4_post_m0_gnt", m0_gnt, 1);
      chk("t4_post_m1_gnt", m1_gnt, 0);
      tick;
      m0_req = 0; m1_req = 0;
      #1;
      chk("t4_post_m0_rvalid", m0_rvalid, 1);
      chk("t4_post_m0_rdata",  m0_rdata,  32'hA0A0_0010);
      chk("t4_post_m1_rvalid", m1_rvalid, 0);
      tick;

`ifdef DMEM_ADDR_CHECK_EN
      // 5: out-of-range write is granted but suppressed and flagged
      m1_req = 1; m1_we = 1; m1_lock = 0; m1_addr = 1024; m1_wdata = 1;
      #1;
      chk("t5_gnt",   m1_gnt, 1);
      chk("t5_memwe", mem_we, 0);
      tick;
      m1_we = 0; m1_addr = 0;
      #1;
      chk("t5_err",    m1_err,    1);
      chk("t5_rvalid", m1_rvalid, 1);
      chk("t5_rdata",  m1_rdata,  0);
      tick;
      m1_req = 0;
      #1;
      chk("t5_rd0_rdata", m1_rdata, 100);
      chk("t5_rd0_err",   m1_err,   0);
      tick;
`else
      // 5: without the check, a read never raises err
      m1_req = 1; m1_we = 0; m1_lock = 0; m1_addr = 0;
      tick;
      m1_req = 0;
      #1;
      chk("t5_nochk_rdata", m1_rdata, 100);
      chk("t5_nochk_err",   m1_err,   0);
      tick;
`endif

      // 6: m1 alone, alternating write/read on addr 7
      for (int k = 0; k < 3; k++) begin
         m1_req = 1; m1_we = 1; m1_lock = 0; m1_addr = 7; m1_wdata = 17 * (k + 1);
         #1;
         chk("t6_wr_gnt",   m1_gnt,    1);
         chk("t6_wr_memwe", mem_we,    1);
         chk("t6_wr_rvalid", m1_rvalid, k > 0);
         if (k > 0) chk("t6_rdata", m1_rdata, 17 * k);
         tick;
         m1_we = 0;
         #1;
         chk("t6_rd_gnt",    m1_gnt,    1);
         chk("t6_rd_rvalid", m1_rvalid, 0);
         tick;
      end
      m1_req = 0;
      #1;
      chk("t6_last_rvalid", m1_rvalid, 1);
      chk("t6_last_rdata",  m1_rdata,  51);
      tick;

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
